// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the keyboard frame sequencer.
// FRAME_BITS is the PS/2 frame length (start, 8 data, parity, stop) the
// shifter needs after each load; BREAK_PREFIX is the scan-code break byte.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } kbd_state_t;

  localparam int         FRAME_BITS   = 11;
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  // Shifter load word: code bit 0 lands in bit 8 (sent first), then odd parity.
  function automatic logic [8:0] kbd_encode(input logic [7:0] code);
    logic [7:0] rev;
    for (int i = 0; i < 8; i++) begin
      rev[7-i] = code[i];
    end
    return {rev, ~^code};
  endfunction

endpackage

// File: rtl/kbd_code_fifo.sv
// kbd_code_fifo: small scan-code queue with wrap-around pointers.
// The head entry is visible combinationally so the sequencer can encode it
// on the same edge it pops. A push arriving while full is still taken when a
// pop happens on the same edge, so occupancy simply stays at FIFO_DEPTH.
module kbd_code_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       kbd_clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_wr_data,
  input  logic       i_pop,
  output logic [7:0] o_rd_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int             PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge kbd_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-2 depth wraps naturally.
  always_ff @(posedge kbd_clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_frame_sequencer.sv
// kbd_frame_sequencer: queues scan codes and feeds them one frame at a time
// to a PS/2 frame shifter (load strobe, 11 shift cycles, inter-frame gap).
// Optional build macro KBD_BREAK_EN: each popped code emits code, F0, code.
// Frames inside one code's burst stretch their gap by one cycle so the load
// spacing matches the IDLE cycle separating independent codes.
module kbd_frame_sequencer
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       kbd_clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       key_ready,
  output logic       ld,
  output logic [8:0] frame_data,
  output logic       busy,
  output logic       fifo_full
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);
`ifdef KBD_BREAK_EN
  localparam logic [GAP_W-1:0] GAP_LAST_LONG = GAP_W'(GAP_CYCLES);
`endif

  kbd_state_t       r_state;
  logic [3:0]       r_bit_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_ld;
  logic [8:0]       r_frame_data;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [7:0]       w_head;
`ifdef KBD_BREAK_EN
  logic [7:0]       r_code;
  logic [1:0]       r_frame_idx;
`endif

  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign ld         = r_ld;
  assign frame_data = r_frame_data;
  assign busy       = (r_state != ST_IDLE);
  assign fifo_full  = w_full;
  assign key_ready  = !w_full;

  kbd_code_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .kbd_clk   (kbd_clk),
    .rst_n     (rst_n),
    .i_push    (key_valid),
    .i_wr_data (key_code),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Frame FSM: load strobe/data are registered and only non-zero in LOAD.
  always_ff @(posedge kbd_clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_ld         <= 1'b0;
      r_frame_data <= '0;
`ifdef KBD_BREAK_EN
      r_code       <= '0;
      r_frame_idx  <= '0;
`endif
    end else begin
      r_ld         <= 1'b0;
      r_frame_data <= '0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state      <= ST_LOAD;
            r_ld         <= 1'b1;
            r_frame_data <= kbd_encode(w_head);
`ifdef KBD_BREAK_EN
            r_code       <= w_head;
            r_frame_idx  <= '0;
`endif
          end
        end
        ST_LOAD: begin
          r_state   <= ST_SHIFT;
          r_bit_cnt <= '0;
        end
        ST_SHIFT: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_GAP: begin
`ifdef KBD_BREAK_EN
          if (r_frame_idx != 2'd2) begin
            if (r_gap_cnt == GAP_LAST_LONG) begin
              r_state      <= ST_LOAD;
              r_frame_idx  <= r_frame_idx + 1'b1;
              r_ld         <= 1'b1;
              r_frame_data <= kbd_encode((r_frame_idx == 2'd0) ? BREAK_PREFIX : r_code);
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end else if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
`else
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_frame_sequencer.sv
// tb_kbd_frame_sequencer: scoreboard bench for kbd_frame_sequencer.
// Expected load words are queued when codes are offered; a negedge monitor
// pops one per ld pulse and logs ld cycle numbers for spacing checks.
// Build with +define+KBD_BREAK_EN to exercise the make/break variant.
module tb_kbd_frame_sequencer;

  localparam int GAP    = 2;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 13 + GAP;
`ifdef KBD_BREAK_EN
  localparam int FPC = 3;
`else
  localparam int FPC = 1;
`endif

  logic       kbd_clk;
  logic       rst_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ready;
  logic       ld;
  logic [8:0] frame_data;
  logic       busy;
  logic       fifo_full;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  bit         mon_en = 0;
  logic [8:0] exp_q[$];
  int         ld_cycles[$];

  kbd_frame_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .kbd_clk    (kbd_clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .ld         (ld),
    .frame_data (frame_data),
    .busy       (busy),
    .fifo_full  (fifo_full)
  );

  initial begin
    kbd_clk = 1'b0;
    forever #5 kbd_clk = ~kbd_clk;
  end

  always @(posedge kbd_clk) cyc <= cyc + 1;

  // Reference frame word: shift code LSB-first into a byte, then odd parity.
  function automatic logic [8:0] enc_frame(input logic [7:0] c);
    logic [7:0] r;
    int         ones;
    r    = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      r = {r[6:0], c[i]};
      ones += int'(c[i]);
    end
    return {r, ((ones % 2) == 0)};
  endfunction

  task automatic push_expect(input logic [7:0] c);
    exp_q.push_back(enc_frame(c));
    if (FPC == 3) begin
      exp_q.push_back(enc_frame(8'hF0));
      exp_q.push_back(enc_frame(c));
    end
  endtask

  // Scoreboard monitor
  always @(negedge kbd_clk) begin
    if (mon_en) begin
      if (ld === 1'b1) begin
        ld_cycles.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ld cycle %0d frame_data=%h required no ld", cyc, frame_data);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if (frame_data !== e) begin
            errors++;
            $display("FAIL frame_data cycle %0d got %h required %h", cyc, frame_data, e);
          end else begin
            $display("frame cycle %0d frame_data=%h", cyc, frame_data);
          end
        end
      end else begin
        checks++;
        if (frame_data !== 9'h000) begin
          errors++;
          $display("FAIL idle_frame_data cycle %0d got %h required 000", cyc, frame_data);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    repeat (3) @(negedge kbd_clk);
    mon_en = 1'b1;
    checks++; if (ld !== 1'b0)         begin errors++; $display("FAIL rst_ld got %b required 0", ld); end
    checks++; if (frame_data !== 9'h0) begin errors++; $display("FAIL rst_frame_data got %h required 000", frame_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
    checks++; if (fifo_full !== 1'b0)  begin errors++; $display("FAIL rst_fifo_full got %b required 0", fifo_full); end
    checks++; if (key_ready !== 1'b1)  begin errors++; $display("FAIL rst_key_ready got %b required 1", key_ready); end
    rst_n = 1'b1;
    @(negedge kbd_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b required 0", busy); end
    $display("reset done");
  endtask

  task automatic test_single();
    int lat;
    int n;
    ld_cycles.delete();
    @(negedge kbd_clk);
    key_valid = 1'b1; key_code = 8'h1C; push_expect(8'h1C);
    @(negedge kbd_clk);
    key_valid = 1'b0;
    lat = 1;
    while (ld !== 1'b1 && lat < 6) begin @(negedge kbd_clk); lat++; end
    checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency got %0d required 2", lat); end
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; @(negedge kbd_clk); end
    checks++;
    if (n !== FPC*PERIOD - 1) begin errors++; $display("FAIL single_busy_len got %0d required %0d", n, FPC*PERIOD - 1); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL single_pending got %0d required 0", exp_q.size()); end
    checks++; if (ld_cycles.size() !== FPC) begin errors++; $display("FAIL single_ld_count got %0d required %0d", ld_cycles.size(), FPC); end
    for (int i = 1; i < ld_cycles.size(); i++) begin
      checks++;
      if (ld_cycles[i] - ld_cycles[i-1] !== PERIOD) begin
        errors++; $display("FAIL single_spacing got %0d required %0d", ld_cycles[i] - ld_cycles[i-1], PERIOD);
      end
    end
    $display("single done busy=%0d", n);
  endtask

  task automatic test_back_to_back();
    int n;
    ld_cycles.delete();
    @(negedge kbd_clk);
    key_valid = 1'b1; key_code = 8'h00; push_expect(8'h00);
    @(negedge kbd_clk);
    key_code = 8'hF0; push_expect(8'hF0);
    @(negedge kbd_clk);
    key_valid = 1'b0;
    n = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0) && n < 300) begin @(negedge kbd_clk); n++; end
    checks++; if (n >= 300) begin errors++; $display("FAIL b2b_drain_timeout got %0d cycles required <300", n); end
    checks++; if (ld_cycles.size() !== 2*FPC) begin errors++; $display("FAIL b2b_ld_count got %0d required %0d", ld_cycles.size(), 2*FPC); end
    for (int i = 1; i < ld_cycles.size(); i++) begin
      checks++;
      if (ld_cycles[i] - ld_cycles[i-1] !== PERIOD) begin
        errors++; $display("FAIL b2b_spacing got %0d required %0d", ld_cycles[i] - ld_cycles[i-1], PERIOD);
      end
    end
    $display("back_to_back done");
  endtask

  task automatic test_overflow();
    logic [7:0] codes[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int n;
    ld_cycles.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge kbd_clk);
      checks++;
      if (key_ready !== (i < 5)) begin errors++; $display("FAIL ovf_key_ready push %0d got %b required %b", i, key_ready, (i < 5)); end
      key_valid = 1'b1; key_code = codes[i];
      if (i < 5) push_expect(codes[i]);
    end
    @(negedge kbd_clk);
    key_valid = 1'b0;
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b required 1", fifo_full); end
    n = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0) && n < 600) begin @(negedge kbd_clk); n++; end
    checks++; if (n >= 600) begin errors++; $display("FAIL ovf_drain_timeout got %0d cycles required <600", n); end
    checks++; if (ld_cycles.size() !== 5*FPC) begin errors++; $display("FAIL ovf_ld_count got %0d required %0d", ld_cycles.size(), 5*FPC); end
    for (int i = 1; i < ld_cycles.size(); i++) begin
      checks++;
      if (ld_cycles[i] - ld_cycles[i-1] !== PERIOD) begin
        errors++; $display("FAIL ovf_spacing got %0d required %0d", ld_cycles[i] - ld_cycles[i-1], PERIOD);
      end
    end
    $display("overflow done");
  endtask

  task automatic test_full_pushpop();
    logic [7:0] codes[5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    int n;
    ld_cycles.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge kbd_clk);
      key_valid = 1'b1; key_code = codes[i]; push_expect(codes[i]);
    end
    @(negedge kbd_clk);
    key_valid = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin @(negedge kbd_clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL fpp_idle_timeout got %0d cycles required <200", n); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fpp_full_before got %b required 1", fifo_full); end
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL fpp_ready_before got %b required 0", key_ready); end
    key_valid = 1'b1; key_code = 8'hA5; push_expect(8'hA5);
    @(negedge kbd_clk);
    key_valid = 1'b0;
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fpp_full_after got %b required 1", fifo_full); end
    checks++; if (ld !== 1'b1) begin errors++; $display("FAIL fpp_ld got %b required 1", ld); end
    n = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0) && n < 600) begin @(negedge kbd_clk); n++; end
    checks++; if (n >= 600) begin errors++; $display("FAIL fpp_drain_timeout got %0d cycles required <600", n); end
    checks++; if (ld_cycles.size() !== 6*FPC) begin errors++; $display("FAIL fpp_ld_count got %0d required %0d", ld_cycles.size(), 6*FPC); end
    $display("full_pushpop done");
  endtask

  task automatic test_reset_mid();
    int n;
    ld_cycles.delete();
    @(negedge kbd_clk);
    key_valid = 1'b1; key_code = 8'h1C; push_expect(8'h1C);
    @(negedge kbd_clk);
    key_code = 8'h2A; push_expect(8'h2A);
    @(negedge kbd_clk);
    key_valid = 1'b0;
    n = 0;
    while (ld !== 1'b1 && n < 10) begin @(negedge kbd_clk); n++; end
    checks++; if (n >= 10) begin errors++; $display("FAIL rmid_ld_timeout got %0d cycles required <10", n); end
    repeat (5) @(negedge kbd_clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge kbd_clk);
    checks++; if (ld !== 1'b0)         begin errors++; $display("FAIL rmid_ld got %b required 0", ld); end
    checks++; if (frame_data !== 9'h0) begin errors++; $display("FAIL rmid_frame_data got %h required 000", frame_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rmid_busy got %b required 0", busy); end
    checks++; if (fifo_full !== 1'b0)  begin errors++; $display("FAIL rmid_fifo_full got %b required 0", fifo_full); end
    checks++; if (key_ready !== 1'b1)  begin errors++; $display("FAIL rmid_key_ready got %b required 1", key_ready); end
    rst_n = 1'b1;
    ld_cycles.delete();
    repeat (40) @(negedge kbd_clk);
    checks++; if (ld_cycles.size() !== 0) begin errors++; $display("FAIL rmid_stray_ld got %0d required 0", ld_cycles.size()); end
    key_valid = 1'b1; key_code = 8'h5A; push_expect(8'h5A);
    @(negedge kbd_clk);
    key_valid = 1'b0;
    n = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0) && n < 200) begin @(negedge kbd_clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL rmid_drain_timeout got %0d cycles required <200", n); end
    checks++; if (ld_cycles.size() !== FPC) begin errors++; $display("FAIL rmid_ld_count got %0d required %0d", ld_cycles.size(), FPC); end
    $display("reset_mid done");
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    repeat (2) @(negedge kbd_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
